// File: rtl/pulse_period_meter.sv
// Measures the clk-cycle spacing between rising edges of a pulse stream and
// hands each period to a consumer through a valid/ready result register.
`timescale 1ns/1ps
module pulse_period_meter #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 200_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             clear,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             locked,
    output logic             timeout,
    output logic             overrun
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] prev_meas_q, prev_meas_d;
    logic             prev_valid_q, prev_valid_d;
    logic             period_valid_q, period_valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic             overrun_q, overrun_d;
    logic             pulse_in_q;
    logic             event_s;
    logic             meas_s;

    assign event_s = pulse_in & ~pulse_in_q;

    // Next-state: measurement FSM, result register handshake and status flags.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        period_d       = period_q;
        prev_meas_d    = prev_meas_q;
        prev_valid_d   = prev_valid_q;
        period_valid_d = period_valid_q;
        locked_d       = locked_q;
        timeout_d      = timeout_q;
        overrun_d      = overrun_q;
        meas_s         = 1'b0;

        if (clear) begin
            state_d        = ST_IDLE;
            cnt_d          = '0;
            period_d       = '0;
            prev_valid_d   = 1'b0;
            period_valid_d = 1'b0;
            locked_d       = 1'b0;
            timeout_d      = 1'b0;
            overrun_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (event_s) begin
                        state_d = ST_ARMED;
                        cnt_d   = ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_ARMED: begin
                    // An event on the TIMEOUT cycle still counts as a measurement.
                    if (event_s) begin
                        meas_s = 1'b1;
                        cnt_d  = ONE;
                    end else if (cnt_q == TMO) begin
                        state_d      = ST_IDLE;
                        cnt_d        = '0;
                        timeout_d    = 1'b1;
                        locked_d     = 1'b0;
                        prev_valid_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase

            if (meas_s) begin
                locked_d     = prev_valid_q && (cnt_q == prev_meas_q);
                prev_meas_d  = cnt_q;
                prev_valid_d = 1'b1;
                if (!period_valid_q || period_ready) begin
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else if (period_valid_q && period_ready) begin
                period_valid_d = 1'b0;
            end else begin
                period_valid_d = period_valid_q;
            end
        end
    end

    // State registers; the edge detector keeps tracking pulse_in even under clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            period_q       <= '0;
            prev_meas_q    <= '0;
            prev_valid_q   <= 1'b0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
            overrun_q      <= 1'b0;
            pulse_in_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            prev_meas_q    <= prev_meas_d;
            prev_valid_q   <= prev_valid_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            timeout_q      <= timeout_d;
            overrun_q      <= overrun_d;
            pulse_in_q     <= pulse_in;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;
    assign overrun      = overrun_q;

endmodule
